// File: rtl/sonar_scheduler.sv
// sonar_scheduler: time-multiplexes four ultrasonic rangers (L, R, F1, F2) so only one
// transmits at a time. Each channel in turn is triggered, its echo pulse width is timed and
// converted to whole centimetres, and the result is latched per channel.
//
// Ports:
//   clk_50m          in   system clock (50 MHz)
//   rst              in   asynchronous, active-high reset
//   en               in   scan enable, sampled in IDLE and at the end of GUARD
//   echo[3:0]        in   raw echo inputs (async); bit 0 = L, 1 = R, 2 = F1, 3 = F2
//   trig[3:0]        out  trigger outputs, at most one bit high
//   dist_l/r/f1/f2   out  latched distance in cm, 4095 = no echo / out of range
//   upd[3:0]         out  one-cycle pulse on the channel whose distance was just written
//   cur_ch[1:0]      out  channel currently being serviced
//   busy             out  high in every state except IDLE
module sonar_scheduler #(
  parameter int unsigned TRIG_CYCLES  = 500,
  parameter int unsigned CM_CYCLES    = 2900,
  parameter int unsigned ECHO_TIMEOUT = 1500000,
  parameter int unsigned GUARD_CYCLES = 500000
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  echo,
  output logic [3:0]  trig,
  output logic [11:0] dist_l,
  output logic [11:0] dist_r,
  output logic [11:0] dist_f1,
  output logic [11:0] dist_f2,
  output logic [3:0]  upd,
  output logic [1:0]  cur_ch,
  output logic        busy
);

  localparam int unsigned MaxAB  = (ECHO_TIMEOUT > GUARD_CYCLES) ? ECHO_TIMEOUT : GUARD_CYCLES;
  localparam int unsigned MaxCnt = (MaxAB > TRIG_CYCLES) ? MaxAB : TRIG_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned SubW   = $clog2(CM_CYCLES + 1);

  localparam logic [11:0] NoEcho = 12'hFFF;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StStore,
    StGuard
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SubW-1:0]   sub_q, sub_d;
  logic [11:0]       cm_q, cm_d;
  logic [1:0]        ch_q, ch_d;
  logic [3:0]        trig_q, trig_d;
  logic [3:0]        upd_q, upd_d;
  logic [11:0]       dist_q [4];
  logic [3:0]        echo_meta_q, echo_sync_q, echo_prev_q;

  logic              sel_sync, sel_prev, echo_rise, echo_fall;
  logic [SubW-1:0]   sub_step;
  logic [11:0]       cm_step;
  logic              store;
  logic [11:0]       store_val;
  logic [3:0]        ch_onehot;

  // Edge detection on the synchronised echo of the selected channel only.
  assign sel_sync  = echo_sync_q[ch_q];
  assign sel_prev  = echo_prev_q[ch_q];
  assign echo_rise = sel_sync & ~sel_prev;
  assign echo_fall = ~sel_sync & sel_prev;
  assign ch_onehot = 4'b0001 << ch_q;

  // One measured high cycle: advance the sub-counter, roll it into whole centimetres.
  always_comb begin
    sub_step = sub_q + 1'b1;
    cm_step  = cm_q;
    if (sub_step == SubW'(CM_CYCLES)) begin
      sub_step = '0;
      if (cm_q != NoEcho) begin
        cm_step = cm_q + 12'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    store     = 1'b0;
    store_val = NoEcho;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StTrig;
        end
      end
      StTrig: begin
        if (cnt_q == CntW'(TRIG_CYCLES - 1)) begin
          state_d = StWaitRise;
        end
      end
      StWaitRise: begin
        sub_d = '0;
        cm_d  = '0;
        if (echo_rise) begin
          state_d = StMeasure;
        end else if (cnt_q == CntW'(ECHO_TIMEOUT)) begin
          state_d   = StStore;
          store     = 1'b1;
          store_val = NoEcho;
        end
      end
      StMeasure: begin
        // The cycle in which the fall is seen still counts as a high cycle.
        sub_d = sub_step;
        cm_d  = cm_step;
        if (echo_fall) begin
          state_d   = StStore;
          store     = 1'b1;
          store_val = cm_step;
        end else if (cnt_q == CntW'(ECHO_TIMEOUT - 1)) begin
          state_d   = StStore;
          store     = 1'b1;
          store_val = NoEcho;
        end
      end
      StStore: begin
        state_d = StGuard;
      end
      StGuard: begin
        if (cnt_q == CntW'(GUARD_CYCLES - 1)) begin
          ch_d    = ch_q + 2'd1;
          state_d = en ? StTrig : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared counter restarts on every state change.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // Registered outputs: trig follows TRIG state by one cycle; the distance and its upd pulse
  // land together on the edge that enters STORE.
  assign trig_d = (state_q == StTrig) ? ch_onehot : 4'b0000;
  assign upd_d  = store ? ch_onehot : 4'b0000;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sub_q       <= '0;
      cm_q        <= '0;
      ch_q        <= '0;
      trig_q      <= '0;
      upd_q       <= '0;
      echo_meta_q <= '0;
      echo_sync_q <= '0;
      echo_prev_q <= '0;
      for (int i = 0; i < 4; i++) begin
        dist_q[i] <= NoEcho;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      cm_q        <= cm_d;
      ch_q        <= ch_d;
      trig_q      <= trig_d;
      upd_q       <= upd_d;
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      echo_prev_q <= echo_sync_q;
      if (store) begin
        dist_q[ch_q] <= store_val;
      end
    end
  end

  assign trig    = trig_q;
  assign upd     = upd_q;
  assign cur_ch  = ch_q;
  assign busy    = (state_q != StIdle);
  assign dist_l  = dist_q[0];
  assign dist_r  = dist_q[1];
  assign dist_f1 = dist_q[2];
  assign dist_f2 = dist_q[3];

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with shortened timing parameters.
module tb_sonar_scheduler;

  localparam int TRIG  = 5;
  localparam int CM    = 10;
  localparam int TOUT  = 200;
  localparam int GUARD = 30;

  logic        clk_50m = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  echo;
  logic [3:0]  trig;
  logic [11:0] dist_l, dist_r, dist_f1, dist_f2;
  logic [3:0]  upd;
  logic [1:0]  cur_ch;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  sonar_scheduler #(
    .TRIG_CYCLES  (TRIG),
    .CM_CYCLES    (CM),
    .ECHO_TIMEOUT (TOUT),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .en      (en),
    .echo    (echo),
    .trig    (trig),
    .dist_l  (dist_l),
    .dist_r  (dist_r),
    .dist_f1 (dist_f1),
    .dist_f2 (dist_f2),
    .upd     (upd),
    .cur_ch  (cur_ch),
    .busy    (busy)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dist_of(input int ch);
    case (ch)
      0:       return int'(dist_l);
      1:       return int'(dist_r);
      2:       return int'(dist_f1);
      default: return int'(dist_f2);
    endcase
  endfunction

  // Monitor: trig exclusivity, spacing of trig rises and the order channels are triggered in.
  int cyc = 0;
  int overlap = 0;
  int last_rise = -1;
  int min_gap = 1 << 30;
  logic [3:0] prev_trig = '0;
  int order[$];

  always @(posedge clk_50m) cyc++;

  always @(negedge clk_50m) begin
    if ($countones(trig) > 1) overlap++;
    if (rst) begin
      last_rise = -1;
      prev_trig = '0;
    end else begin
      if ((trig & ~prev_trig) != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (trig[i] && !prev_trig[i]) order.push_back(i);
        if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
        last_rise = cyc;
      end
      prev_trig = trig;
    end
  end

  // Wait for trig[ch] to rise, then measure its high time; returns at the first low negedge.
  task automatic trig_phase(input int ch);
    int n;
    int hi;
    n = 0;
    while (!trig[ch] && n < 2000) begin
      @(negedge clk_50m);
      n++;
    end
    check($sformatf("trig%0d_rise", ch), int'(trig[ch]), 1);
    hi = 0;
    while (trig[ch] && hi < 2000) begin
      @(negedge clk_50m);
      hi++;
    end
    check($sformatf("trig%0d_len", ch), hi, TRIG);
  endtask

  // Service one channel with an echo pulse of 'width' cycles starting 'dly' cycles after trig
  // falls; checks the fall-to-upd latency, the pulse length and the stored distance.
  task automatic service(input int ch, input int dly, input int width, input int exp_cm,
                         input bit drop_en);
    trig_phase(ch);
    repeat (dly) @(negedge clk_50m);
    echo[ch] = 1'b1;
    repeat (width) @(negedge clk_50m);
    if (drop_en) en = 1'b0;
    echo[ch] = 1'b0;
    @(negedge clk_50m);
    check($sformatf("ch%0d_upd_early1", ch), int'(upd), 0);
    @(negedge clk_50m);
    check($sformatf("ch%0d_upd_early2", ch), int'(upd), 0);
    @(negedge clk_50m);
    check($sformatf("ch%0d_upd", ch), int'(upd), 1 << ch);
    check($sformatf("ch%0d_dist_w%0d", ch, width), dist_of(ch), exp_cm);
    @(negedge clk_50m);
    check($sformatf("ch%0d_upd_end", ch), int'(upd), 0);
  endtask

  // Count negedges until upd goes non-zero (bounded).
  task automatic count_to_upd(output int c);
    c = 0;
    while (upd == 4'b0000 && c < 2000) begin
      @(negedge clk_50m);
      c++;
    end
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int trig_seen;
    rst  = 1'b1;
    en   = 1'b0;
    echo = 4'b0000;
    repeat (3) @(negedge clk_50m);
    check("rst_trig", int'(trig), 0);
    check("rst_upd", int'(upd), 0);
    check("rst_cur_ch", int'(cur_ch), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dist_l", int'(dist_l), 4095);
    check("rst_dist_f2", int'(dist_f2), 4095);
    rst = 1'b0;
    @(negedge clk_50m);
    check("idle_busy", int'(busy), 0);

    // Scan 1: en rise to trig[0] takes two edges.
    en = 1'b1;
    @(negedge clk_50m);
    check("lat_trig_c1", int'(trig), 0);
    check("lat_busy_c1", int'(busy), 1);
    @(negedge clk_50m);
    check("lat_trig_c2", int'(trig), 1);
    service(0, 100, 75, 7, 1'b0);
    check("s1_dist_r_hold", int'(dist_r), 4095);
    check("s1_dist_f1_hold", int'(dist_f1), 4095);
    check("s1_dist_f2_hold", int'(dist_f2), 4095);
    service(1, 3, 9, 0, 1'b0);
    // ch2: no echo, timeout counted from trig falling.
    trig_phase(2);
    count_to_upd(c);
    check("ch2_norise_lat", c, TOUT);
    check("ch2_norise_upd", int'(upd), 4);
    check("ch2_norise_dist", int'(dist_f1), 4095);
    service(3, 3, 25, 2, 1'b0);

    // Scan 2.
    service(0, 3, 40, 4, 1'b0);
    service(1, 3, 10, 1, 1'b0);
    // ch2: echo rises then sticks high; timeout counted in high cycles.
    trig_phase(2);
    repeat (3) @(negedge clk_50m);
    echo[2] = 1'b1;
    count_to_upd(c);
    check("ch2_stuck_lat", c, TOUT + 3);
    check("ch2_stuck_upd", int'(upd), 4);
    check("ch2_stuck_dist", int'(dist_f1), 4095);
    echo[2] = 1'b0;
    // ch3: en drops during MEASURE, channel still completes.
    service(3, 3, 19, 1, 1'b1);
    repeat (GUARD + 5) @(negedge clk_50m);
    check("endis_cur_ch", int'(cur_ch), 0);
    check("endis_busy", int'(busy), 0);
    trig_seen = 0;
    repeat (50) begin
      @(negedge clk_50m);
      if (trig != 4'b0000) trig_seen++;
    end
    check("endis_no_trig", trig_seen, 0);

    // Scan 3, with noise on ch0 while ch2 is serviced.
    en = 1'b1;
    service(0, 3, 11, 1, 1'b0);
    service(1, 3, 19, 1, 1'b0);
    echo[0] = 1'b1;
    service(2, 5, 59, 5, 1'b0);
    echo[0] = 1'b0;
    check("noise_dist_l_hold", int'(dist_l), 1);
    service(3, 3, 3, 0, 1'b0);

    // Scan 4: reset while ch1 triggers.
    service(0, 3, 30, 3, 1'b0);
    c = 0;
    while (!trig[1] && c < 2000) begin
      @(negedge clk_50m);
      c++;
    end
    check("pre_rst_trig1", int'(trig), 2);
    @(negedge clk_50m);
    rst = 1'b1;
    #1;
    check("rst_mid_trig", int'(trig), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_cur_ch", int'(cur_ch), 0);
    check("rst_mid_dist_l", int'(dist_l), 4095);
    check("rst_mid_dist_r", int'(dist_r), 4095);
    check("rst_mid_dist_f1", int'(dist_f1), 4095);
    check("rst_mid_dist_f2", int'(dist_f2), 4095);
    @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);
    check("restart_trig_c1", int'(trig), 0);
    @(negedge clk_50m);
    check("restart_trig_c2", int'(trig), 1);
    repeat (3) @(negedge clk_50m);

    check("trig_onehot", overlap, 0);
    check("trig_gap_ok", int'(min_gap >= GUARD), 1);
    check("order_len", order.size(), 15);
    for (int i = 0; i < order.size() && i < 15; i++) begin
      check($sformatf("order%0d", i), order[i], (i < 14) ? (i % 4) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
